// File: rtl/dmem_resp.sv
// Single-port 256x32 data memory responder for the memory-stage mreq/mres handshake.
// Optional feature macro: DMEM_STATS_EN adds saturating read/write access counters.
module dmem_resp #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mreq,
  input  logic [3:0]  w_mem,
  input  logic [7:0]  addr_mem,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        mres,
`ifdef DMEM_STATS_EN
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [7:0]  addr_q;
  logic [3:0]  we_q;
  logic [31:0] data_q;
  logic [31:0] load_q;
  logic [31:0] mem [256];

  logic        accept;
  logic        do_access;
  logic        is_write;
  logic [7:0]  acc_addr;
  logic [3:0]  acc_we;
  logic [31:0] acc_data;
  logic [31:0] merged;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (mreq) begin
          wcnt_d  = 4'(LATENCY);
          state_d = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero latency the access happens on the accept edge itself, so the
  // operands come straight from the request being latched on that edge.
  always_comb begin
    accept    = (state_q == IDLE) && mreq;
    do_access = (state_d == RESP) && (state_q != RESP);
    acc_addr  = (state_q == IDLE) ? addr_mem   : addr_q;
    acc_we    = (state_q == IDLE) ? w_mem      : we_q;
    acc_data  = (state_q == IDLE) ? store_data : data_q;
    is_write  = |acc_we;
    merged    = mem[acc_addr];
    for (int i = 0; i < 4; i++) begin
      if (acc_we[i]) merged[8*i +: 8] = acc_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= 8'd0;
      we_q    <= 4'd0;
      data_q  <= 32'd0;
      load_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (accept) begin
        addr_q <= addr_mem;
        we_q   <= w_mem;
        data_q <= store_data;
      end
      if (do_access) load_q <= merged;
    end
  end

  // The array itself is never reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (do_access && is_write) mem[acc_addr] <= merged;
  end

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else if (do_access) begin
      if (is_write && (wr_cnt_q != 16'hFFFF)) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (!is_write && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

  assign load_data = load_q;
  assign mres      = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: one instance at LATENCY=2, one at LATENCY=0,
// checked against a behavioural word-array model of the memory.
module tb_dmem_resp;

  localparam int LAT  = 2;
  localparam int LAT0 = 0;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic        mreq = 1'b0, mreq0 = 1'b0;
  logic [3:0]  wMem = '0, wMem0 = '0;
  logic [7:0]  addrMem = '0, addrMem0 = '0;
  logic [31:0] storeData = '0, storeData0 = '0;
  logic [31:0] loadData, loadData0;
  logic        mres, mres0, busy, busy0;
`ifdef DMEM_STATS_EN
  logic [15:0] rdCnt, wrCnt, rdCnt0, wrCnt0;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] model  [256];
  logic [31:0] model0 [256];
  int rdExp = 0;
  int wrExp = 0;

  always #5 clk = ~clk;

  dmem_resp #(.LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn), .mreq(mreq), .w_mem(wMem), .addr_mem(addrMem),
    .store_data(storeData), .load_data(loadData), .mres(mres),
`ifdef DMEM_STATS_EN
    .rd_cnt(rdCnt), .wr_cnt(wrCnt),
`endif
    .busy(busy)
  );

  dmem_resp #(.LATENCY(LAT0)) dut0 (
    .clk(clk), .resetn(resetn), .mreq(mreq0), .w_mem(wMem0), .addr_mem(addrMem0),
    .store_data(storeData0), .load_data(loadData0), .mres(mres0),
`ifdef DMEM_STATS_EN
    .rd_cnt(rdCnt0), .wr_cnt(wrCnt0),
`endif
    .busy(busy0)
  );

  // Drives one request on the selected instance, waits (bounded) for its mres,
  // and returns the response word, the accept-to-mres cycle count and early busy.
  task automatic doReq(input bit z, input logic [3:0] we, input logic [7:0] a,
                       input logic [31:0] d, output logic [31:0] ld,
                       output int lat, output logic b1);
    @(negedge clk);
    if (z) begin mreq0 = 1'b1; wMem0 = we; addrMem0 = a; storeData0 = d; end
    else   begin mreq  = 1'b1; wMem  = we; addrMem  = a; storeData  = d; end
    @(posedge clk);
    lat = 0;
    b1  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) b1 = z ? busy0 : busy;
      if ((z ? mres0 : mres) === 1'b1) break;
    end
    ld = z ? loadData0 : loadData;
    if (z) mreq0 = 1'b0; else mreq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        if (z) model0[a][8*i +: 8] = d[8*i +: 8];
        else   model[a][8*i +: 8]  = d[8*i +: 8];
      end
    end
    if (!z) begin
      if (we != 4'd0) wrExp++; else rdExp++;
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    rdExp = 0;
    wrExp = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (mres !== 1'b0) begin errors++; $display("[TB] FAIL reset_mres: got %b expected 0", mres); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (loadData !== 32'h0) begin errors++; $display("[TB] FAIL reset_load: got %h expected 00000000", loadData); end
    checks++; if (mres0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_mres0: got %b expected 0", mres0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy0: got %b expected 0", busy0); end
    checks++; if (loadData0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_load0: got %h expected 00000000", loadData0); end
`ifdef DMEM_STATS_EN
    checks++; if (rdCnt !== 16'd0 || wrCnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", rdCnt, wrCnt); end
`endif
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] ld; int lat; logic b1;
    doReq(1'b0, 4'b1111, 8'h10, 32'hDEADBEEF, ld, lat, b1);
    checks++; if (lat !== LAT + 1) begin errors++; $display("[TB] FAIL wr_latency: got %0d expected %0d", lat, LAT + 1); end
    checks++; if (ld !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr_load: got %h expected deadbeef", ld); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("[TB] FAIL wr_busy: got %b expected 1", b1); end
    @(negedge clk);
    checks++; if (mres !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mres_one_cycle: got mres=%b busy=%b expected 0/0", mres, busy); end
    doReq(1'b0, 4'b0000, 8'h10, 32'h0, ld, lat, b1);
    checks++; if (lat !== LAT + 1) begin errors++; $display("[TB] FAIL rd_latency: got %0d expected %0d", lat, LAT + 1); end
    checks++; if (ld !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_load: got %h expected deadbeef", ld); end
  endtask

  task automatic test_byte_lane();
    logic [31:0] ld; int lat; logic b1;
    doReq(1'b0, 4'b1111, 8'h05, 32'h11223344, ld, lat, b1);
    doReq(1'b0, 4'b0100, 8'h05, 32'h00AA0000, ld, lat, b1);
    checks++; if (ld !== 32'h11AA3344) begin errors++; $display("[TB] FAIL lane_wr_load: got %h expected 11aa3344", ld); end
    doReq(1'b0, 4'b0000, 8'h05, 32'h0, ld, lat, b1);
    checks++; if (ld !== 32'h11AA3344) begin errors++; $display("[TB] FAIL lane_rd_load: got %h expected 11aa3344", ld); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ld; int lat; logic b1;
    doReq(1'b1, 4'b1111, 8'h01, 32'hA5A5_0101, ld, lat, b1);
    checks++; if (lat !== LAT0 + 1) begin errors++; $display("[TB] FAIL l0_latency: got %0d expected %0d", lat, LAT0 + 1); end
    doReq(1'b1, 4'b1111, 8'h02, 32'h5A5A_0202, ld, lat, b1);
    @(negedge clk);
    mreq0 = 1'b1; wMem0 = 4'b0000; addrMem0 = 8'h01;
    @(posedge clk);
    @(negedge clk);
    checks++; if (mres0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_mres1: got %b expected 1", mres0); end
    checks++; if (loadData0 !== model0[8'h01]) begin errors++; $display("[TB] FAIL b2b_load1: got %h expected %h", loadData0, model0[8'h01]); end
    addrMem0 = 8'h02;
    @(negedge clk);
    checks++; if (mres0 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap: got %b expected 0", mres0); end
    @(negedge clk);
    checks++; if (mres0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_mres2: got %b expected 1", mres0); end
    checks++; if (loadData0 !== model0[8'h02]) begin errors++; $display("[TB] FAIL b2b_load2: got %h expected %h", loadData0, model0[8'h02]); end
    mreq0 = 1'b0;
  endtask

  task automatic test_drop_in_wait();
    logic [31:0] ld; int lat; logic b1; int pulses;
    doReq(1'b0, 4'b1111, 8'h20, 32'h12345678, ld, lat, b1);
    @(negedge clk);
    mreq = 1'b1; wMem = 4'b0000; addrMem = 8'h10;
    @(posedge clk);
    @(negedge clk);
    addrMem = 8'h20; mreq = 1'b0;
    lat = 1;
    for (int c = 0; c < 40 && mres !== 1'b1; c++) begin
      @(negedge clk);
      lat++;
    end
    rdExp++;
    checks++; if (lat !== LAT + 1) begin errors++; $display("[TB] FAIL drop_latency: got %0d expected %0d", lat, LAT + 1); end
    checks++; if (loadData !== model[8'h10]) begin errors++; $display("[TB] FAIL drop_load: got %h expected %h", loadData, model[8'h10]); end
    pulses = 0;
    repeat (4) begin @(negedge clk); if (mres === 1'b1) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL drop_single_pulse: got %0d extra expected 0", pulses); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ld; int lat; logic b1;
    doReq(1'b0, 4'b1111, 8'h30, 32'h0, ld, lat, b1);
    @(negedge clk);
    mreq = 1'b1; wMem = 4'b1111; addrMem = 8'h30; storeData = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    mreq = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
    resetn = 1'b0;
    #1;
    checks++; if (mres !== 1'b0) begin errors++; $display("[TB] FAIL mid_mres: got %b expected 0", mres); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (loadData !== 32'h0) begin errors++; $display("[TB] FAIL mid_load: got %h expected 00000000", loadData); end
    @(negedge clk);
    resetn = 1'b1;
    rdExp = 0; wrExp = 0;
    doReq(1'b0, 4'b0000, 8'h30, 32'h0, ld, lat, b1);
    checks++; if (ld !== 32'h0) begin errors++; $display("[TB] FAIL mid_dropped_write: got %h expected 00000000", ld); end
  endtask

  task automatic test_random();
    logic [31:0] ld; int lat; logic b1; logic [7:0] a; logic [3:0] we; logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      doReq(1'b0, 4'b1111, 8'(i), $urandom, ld, lat, b1);
      doReq(1'b1, 4'b1111, 8'(i), $urandom, ld, lat, b1);
    end
    for (int n = 0; n < 24; n++) begin
      a  = 8'($urandom_range(0, 7));
      we = 4'($urandom_range(0, 15));
      d  = $urandom;
      doReq(n[0], we, a, d, ld, lat, b1);
      checks++;
      if (ld !== (n[0] ? model0[a] : model[a])) begin
        errors++; $display("[TB] FAIL rand_load[%0d]: got %h expected %h", n, ld, n[0] ? model0[a] : model[a]);
      end
      checks++;
      if (lat !== (n[0] ? LAT0 + 1 : LAT + 1)) begin
        errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, n[0] ? LAT0 + 1 : LAT + 1);
      end
    end
  endtask

`ifdef DMEM_STATS_EN
  task automatic test_stats();
    logic [31:0] ld; int lat; logic b1;
    pulseReset();
    doReq(1'b0, 4'b1111, 8'h40, 32'h1, ld, lat, b1);
    doReq(1'b0, 4'b0000, 8'h40, 32'h0, ld, lat, b1);
    doReq(1'b0, 4'b0011, 8'h41, 32'h2, ld, lat, b1);
    doReq(1'b0, 4'b0000, 8'h40, 32'h0, ld, lat, b1);
    doReq(1'b0, 4'b0000, 8'h41, 32'h0, ld, lat, b1);
    @(negedge clk);
    checks++; if (rdCnt !== 16'(rdExp) || rdExp != 3) begin errors++; $display("[TB] FAIL stats_rd: got %0d expected 3", rdCnt); end
    checks++; if (wrCnt !== 16'(wrExp) || wrExp != 2) begin errors++; $display("[TB] FAIL stats_wr: got %0d expected 2", wrCnt); end
    pulseReset();
    #1;
    checks++; if (rdCnt !== 16'd0 || wrCnt !== 16'd0) begin errors++; $display("[TB] FAIL stats_reset: got %0d/%0d expected 0/0", rdCnt, wrCnt); end
  endtask
`endif

  initial begin
    $display("[TB] starting dmem_resp bench");
    test_reset();
    test_write_read();
    test_byte_lane();
    test_back_to_back();
    test_drop_in_wait();
    test_reset_mid();
    test_random();
`ifdef DMEM_STATS_EN
    test_stats();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Single-port 256×32 data memory responder serving the memory stage's `mreq`/`mres` handshake. It latches the stage's request (word address, byte write enables, store data), inserts a programmable number of wait cycles, then performs a byte-lane write or a full-word read. It returns `load_data` with a one-cycle `mres` pulse. It sits between the pipeline's memory stage and the data RAM array, as the responder end of that interface.

## Interface
- `LATENCY`, default 2: wait cycles between request acceptance and response; legal range 0..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `mreq`  in  1  request from the memory stage; held high until `mres` is seen.
- `w_mem`  in  4  byte write enables, bit i selects `store_data[8i+7:8i]`; 4'b0000 means read.
- `addr_mem`  in  8  word address (byte address bits [9:2]).
- `store_data`  in  32  write data, already lane-aligned by the requester.
- `load_data`  out  32  registered read word; held stable between responses.
- `mres`  out  1  response strobe, exactly one cycle per accepted request.
- `busy`  out  1  high from acceptance through the `mres` cycle.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - `mreq`=1 at an edge → latch `addr_mem`, `w_mem`, `store_data` into request registers and load `wcnt`=LATENCY.
  - Next state is WAIT if LATENCY>0, else RESP.
- WAIT: `wcnt` decrements each cycle; at `wcnt`==1 the next state is RESP.
- On the edge entering RESP, the access is performed using the latched request only:
  - Write (`w_mem`≠0): for each set bit i, mem[addr][8i+7:8i] ← store byte i. Unselected bytes are unchanged. `load_data` ← post-write merged word.
  - Read: `load_data` ← mem[addr].
- RESP: `mres`=1 for exactly this cycle; the next state is unconditionally IDLE.
- Requester protocol: `mreq` must be low on the edge following the `mres` cycle. If `mreq` is still high in IDLE, it is a new request.
- `mreq` dropping during WAIT does not abort; the access completes and `mres` still pulses.
- Input changes after acceptance are ignored.
- `busy` = (state≠IDLE).
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset values: state IDLE, `mres`=0, `busy`=0, `load_data`=32'h0, `wcnt`=0.
- `resetn` low at any time, including WAIT or RESP, forces reset values immediately. An in-flight write whose RESP edge has not occurred is dropped.
- Latency: `mreq` sampled high at edge k → `mres` high in cycle k+1+LATENCY, with `load_data` valid in that same cycle.
- With LATENCY=0, `mres` is high in the cycle right after acceptance.
- Throughput: one request per LATENCY+2 cycles; the earliest re-acceptance is the edge after RESP.
- All outputs are registered or derived from state only; no combinational path from inputs to outputs.

## Configuration
- `DMEM_STATS_EN` defined:
  - Adds output ports `rd_cnt[15:0]` and `wr_cnt[15:0]`, each reset to 0.
  - Each counter increments on the edge entering RESP for a read or a write respectively.
  - Counters saturate at 16'hFFFF.
- `DMEM_STATS_EN` undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- LATENCY=2, full write then read:
  - Write addr 8'h10, `w_mem`=4'b1111, data 32'hDEADBEEF → `mres` 3 cycles after the accept edge.
  - Read addr 8'h10 → `load_data`=32'hDEADBEEF with `mres`.
- Byte-lane write:
  - Preload addr 8'h05 with 32'h11223344.
  - Write `w_mem`=4'b0100, data 32'h00AA0000 → write response `load_data`=32'h11AA3344; a subsequent read returns the same.
- LATENCY=0, back-to-back:
  - Hold `mreq` high continuously, reads of 8'h01 then 8'h02.
  - Required: `mres` on alternating cycles (cycles 1 and 3 after the first accept), each with the correct word.
- Input change and `mreq` drop during WAIT:
  - Accept a read of 8'h10, then change `addr_mem` to 8'h20 and drop `mreq` in WAIT.
  - Required: `mres` still pulses once and `load_data` is mem[8'h10].
- Reset mid-operation:
  - Assert `resetn`=0 during WAIT of a write to 8'h30 (old value 32'h0).
  - Required: `mres`=0, `busy`=0 and `load_data`=0 immediately; after release, a read of 8'h30 returns 32'h0.
- With `DMEM_STATS_EN`: 3 reads and 2 writes → `rd_cnt`=3, `wr_cnt`=2; after reset both are 0.
